op_dispatch: RTL and testbench
==============================

Name: op_dispatch

Overview:
- Front end of the FP coprocessor datapath.
- Accepts CPU-pushed commands (opcode plus two 32-bit operands) into an 8-entry command FIFO.
- Issues one command at a time to the add, mul or sine unit with a one-cycle start pulse.
- Presents the in-flight opcode as a tag to the output collector, and releases the next command when the collector signals the result was serviced.

Parameters:
- DEPTH, 8: command FIFO entries; power of two.
- DATA_W, 32: operand width (IEEE-754 single).
- TIMEOUT, 255: watchdog limit in cycles; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_push  in  1  write command this cycle
- cpu_opcode  in  3  command opcode
- cpu_op_a  in  DATA_W  operand A
- cpu_op_b  in  DATA_W  operand B
- in_full  out  1  command FIFO holds DEPTH entries
- in_count  out  4  occupancy, 0..DEPTH
- out_fifo_hold  in  1  output collector full; block new issue
- op_fifo_pop  in  1  one-cycle pulse: in-flight result captured downstream
- op_tag  out  3  in-flight opcode; 000 when nothing is in flight
- operand_a  out  DATA_W  registered operand A to units
- operand_b  out  DATA_W  registered operand B to units; sign bit inverted for SUB
- add_start  out  1  one-cycle start to adder (ADD, SUB)
- mul_start  out  1  one-cycle start to multiplier (MUL)
- sine_start  out  1  one-cycle start to sine unit (SIN, COS)
- sine_cos  out  1  registered; 1 selects cosine
- err_illegal  out  1  sticky; illegal opcode dropped
- err_overflow  out  1  sticky; push while full dropped

Behaviour:
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 SIN, 101 COS, 110/111 illegal.
- Reset (sync, rst high at posedge):
  - FIFO emptied; pointers and count = 0.
  - State = IDLE.
  - All outputs 0; sticky error flags cleared.
- Reset mid-operation discards the in-flight command. Any downstream done after that is not acknowledged by this block.
- FIFO write:
  - cpu_push with count < DEPTH stores {opcode, a, b} at the write pointer. The entry is visible the next cycle.
  - cpu_push with count == DEPTH is dropped and sets err_overflow, even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous accepted push and pop leaves the count unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if count > 0 and !out_fifo_hold, pop the head and register its operands.
    - Opcode 000: discard silently, stay IDLE.
    - Opcode 110/111: discard, set err_illegal, stay IDLE.
    - Otherwise: go to ISSUE.
  - ISSUE (exactly one cycle):
    - Assert exactly one start pulse selected by opcode.
    - op_tag = opcode, held until release.
    - operand_a/operand_b stable from ISSUE until leaving WAIT.
    - Go to WAIT.
  - WAIT: on op_fifo_pop, op_tag returns to 000 the next cycle and the state returns to IDLE. Otherwise stay.
  - op_fifo_pop outside WAIT is ignored.
- Latency: push at cycle N into an empty FIFO in IDLE gives pop at N+1 and start pulse plus op_tag valid at N+2. Minimum command-to-command spacing is 3 cycles plus unit latency.
- SUB: operand_b = {~b[31], b[30:0]}; uses add_start.
- COS: sine_cos = 1. SIN: sine_cos = 0.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- With the macro:
  - An 8-bit watchdog counter runs in WAIT.
  - If TIMEOUT cycles pass without op_fifo_pop: go to IDLE, op_tag = 000, and pulse err_timeout (extra 1-bit output port) for one cycle.
  - The command is lost; the counter clears on entering WAIT.
- Without the macro: no counter, no err_timeout port; WAIT waits indefinitely.

Decomposition:
- Package fp_pkg:
  - Opcode enum typedef (OP_NOP..OP_COS).
  - Dispatch state enum.
  - DATA_W constant.
  - Command struct typedef {opcode, a, b}.
- One sub-module, cmd_fifo:
  - Synchronous FIFO parameterised by DEPTH and entry type.
  - Provides full/empty/count.
  - Implements the drop-on-full rule.

Test Plan:
- Reset, then push ADD a=0x3F800000 b=0x40000000 -> add_start high for one cycle at N+2; op_tag=001; operand_a/b match. Pulse op_fifo_pop -> op_tag=000 next cycle.
- Push SUB b=0x40000000 -> operand_b=0xC0000000 and add_start pulsed. Push COS -> sine_start pulsed with sine_cos=1.
- Push 9 commands back-to-back while stalled in WAIT -> in_full after 8, in_count=8, 9th dropped, err_overflow=1. Drain with 8 op_fifo_pop pulses -> opcodes issued in push order.
- Push opcode 111 then MUL -> err_illegal=1, no start for 111, mul_start pulsed with op_tag=011.
- Hold out_fifo_hold=1 with 2 queued entries -> no start pulses, state IDLE. Release -> first issue 1 cycle later.
- Assert rst during WAIT with 3 queued -> next cycle op_tag=000, in_count=0, flags 0, no start pulses afterwards. With DISPATCH_TIMEOUT_EN, withhold op_fifo_pop for 255 cycles -> err_timeout pulses once and the next command issues.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types for the FP coprocessor front end: opcodes, dispatch states
// and the queued command record.
package fp_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_MUL = 3'b011,
        OP_SIN = 3'b100,
        OP_COS = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } disp_state_e;

    // Opcode kept as raw bits so illegal codes survive the FIFO and can be flagged.
    typedef struct packed {
        logic [2:0]        opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    function automatic logic is_legal(input logic [2:0] op);
        return (op != 3'b110) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a push while full is dropped and reported on
// overflow, even when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign overflow = push && full;
    assign dout     = mem[rd_ptr];

    // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_dispatch.sv
// FP coprocessor dispatcher: queues CPU commands and issues them one at a time.
// Optional WAIT watchdog with err_timeout port when DISPATCH_TIMEOUT_EN is defined.
module op_dispatch
    import fp_pkg::*;
#(
    parameter int DEPTH   = 8
`ifdef DISPATCH_TIMEOUT_EN
    , parameter int TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_push,
    input  logic [2:0]        cpu_opcode,
    input  logic [DATA_W-1:0] cpu_op_a,
    input  logic [DATA_W-1:0] cpu_op_b,
    output logic              in_full,
    output logic [3:0]        in_count,
    input  logic              out_fifo_hold,
    input  logic              op_fifo_pop,
    output logic [2:0]        op_tag,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic              add_start,
    output logic              mul_start,
    output logic              sine_start,
    output logic              sine_cos,
    output logic              err_illegal,
    output logic              err_overflow
`ifdef DISPATCH_TIMEOUT_EN
    , output logic            err_timeout
`endif
);

    disp_state_e state;
    cmd_t        wr_cmd;
    cmd_t        head;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_ovf;

    assign wr_cmd   = '{opcode: cpu_opcode, a: cpu_op_a, b: cpu_op_b};
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !out_fifo_hold;

    cmd_fifo #(.DEPTH(DEPTH), .entry_t(cmd_t)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cpu_push),
        .din      (wr_cmd),
        .pop      (fifo_pop),
        .dout     (head),
        .full     (in_full),
        .empty    (fifo_empty),
        .count    (in_count),
        .overflow (fifo_ovf)
    );

`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0] wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_tag       <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            add_start    <= 1'b0;
            mul_start    <= 1'b0;
            sine_start   <= 1'b0;
            sine_cos     <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            wd_cnt       <= '0;
            err_timeout  <= 1'b0;
`endif
        end else begin
            // NOTE: pulses default low every cycle so each start lasts exactly one clock.
            add_start  <= 1'b0;
            mul_start  <= 1'b0;
            sine_start <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            if (fifo_ovf) err_overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        operand_a <= head.a;
                        operand_b <= (head.opcode == OP_SUB) ?
                                     {~head.b[DATA_W-1], head.b[DATA_W-2:0]} : head.b;
                        if (!is_legal(head.opcode)) begin
                            err_illegal <= 1'b1;
                        end else if (head.opcode != OP_NOP) begin
                            state      <= ST_ISSUE;
                            op_tag     <= head.opcode;
                            add_start  <= (head.opcode == OP_ADD) || (head.opcode == OP_SUB);
                            mul_start  <= (head.opcode == OP_MUL);
                            sine_start <= (head.opcode == OP_SIN) || (head.opcode == OP_COS);
                            sine_cos   <= (head.opcode == OP_COS);
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (op_fifo_pop) begin
                        state  <= ST_IDLE;
                        op_tag <= '0;
                    end
`ifdef DISPATCH_TIMEOUT_EN
                    else if (wd_cnt == 8'(TIMEOUT - 1)) begin
                        state       <= ST_IDLE;
                        op_tag      <= '0;
                        err_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_dispatch.sv
// Scoreboard bench for op_dispatch: stimulus pushes expected issues, a monitor
// compares them whenever a start pulse appears.
module tb_op_dispatch;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_push = 1'b0;
    logic [2:0]  cpu_opcode = '0;
    logic [31:0] cpu_op_a = '0;
    logic [31:0] cpu_op_b = '0;
    logic        in_full;
    logic [3:0]  in_count;
    logic        out_fifo_hold = 1'b0;
    logic        op_fifo_pop;
    logic        man_pop = 1'b0;
    logic        ack_pop = 1'b0;
    logic [2:0]  op_tag;
    logic [31:0] operand_a, operand_b;
    logic        add_start, mul_start, sine_start, sine_cos;
    logic        err_illegal, err_overflow;
`ifdef DISPATCH_TIMEOUT_EN
    logic        err_timeout;
`endif

    assign op_fifo_pop = man_pop | ack_pop;
    always #5 clk = ~clk;

    op_dispatch dut (
        .clk(clk), .rst(rst),
        .cpu_push(cpu_push), .cpu_opcode(cpu_opcode), .cpu_op_a(cpu_op_a), .cpu_op_b(cpu_op_b),
        .in_full(in_full), .in_count(in_count),
        .out_fifo_hold(out_fifo_hold), .op_fifo_pop(op_fifo_pop),
        .op_tag(op_tag), .operand_a(operand_a), .operand_b(operand_b),
        .add_start(add_start), .mul_start(mul_start), .sine_start(sine_start), .sine_cos(sine_cos),
        .err_illegal(err_illegal), .err_overflow(err_overflow)
`ifdef DISPATCH_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   start_events = 0;
    bit   auto_ack = 1'b0;
    bit   exp_illegal = 1'b0;
    bit   exp_overflow = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: subtraction is addition of the negated operand, i.e. sign flipped.
    function automatic logic [31:0] ref_b(input logic [2:0] op, input logic [31:0] b);
        return (op == 3'd2) ? (b ^ 32'h8000_0000) : b;
    endfunction

    function automatic logic [2:0] ref_unit(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 3'b100;
        if (op == 3'd3)               return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit accept);
        cpu_push   = 1'b1;
        cpu_opcode = op;
        cpu_op_a   = a;
        cpu_op_b   = b;
        if (!accept)           exp_overflow = 1'b1;
        else if (op >= 3'd6)   exp_illegal = 1'b1;
        else if (op != 3'd0)   sb.push_back('{op, a, ref_b(op, b)});
        tick();
        cpu_push = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (sb.size() == 0 && op_tag == 3'd0 && in_count == 4'd0 && !ack_pop) done = 1'b1;
            else tick();
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    // Monitor: every start pulse is matched against the oldest expected issue.
    initial begin
        int   n;
        exp_t e;
        forever begin
            @(negedge clk);
            n = int'(add_start) + int'(mul_start) + int'(sine_start);
            if (!rst && n != 0) begin
                start_events++;
                if (n > 1) check("one_start", 32'(n), 32'd1);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: got tag %h expected no issue", op_tag);
                end else begin
                    e = sb.pop_front();
                    check("tag", 32'(op_tag), 32'(e.op));
                    check("operand_a", operand_a, e.a);
                    check("operand_b", operand_b, e.b);
                    check("unit", 32'({add_start, mul_start, sine_start}), 32'(ref_unit(e.op)));
                    if (sine_start) check("sine_cos", 32'(sine_cos), 32'(e.op == 3'd5));
                end
            end
        end
    end

    // Collector model: acknowledges the in-flight result after a random delay.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && !rst && op_tag != 3'd0 && !(add_start | mul_start | sine_start)) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ack_pop = 1'b1;
                @(negedge clk);
                ack_pop = 1'b0;
                check("tag_release", 32'(op_tag), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0;
        logic [31:0] ra;
        tick();
        tick();
        check("rst_tag", 32'(op_tag), 32'd0);
        check("rst_count", 32'(in_count), 32'd0);
        check("rst_full", 32'(in_full), 32'd0);
        check("rst_starts", 32'({add_start, mul_start, sine_start}), 32'd0);
        check("rst_errs", 32'({err_illegal, err_overflow}), 32'd0);
        rst = 1'b0;
        tick();

        // Latency of a single ADD into an empty queue.
        push_cmd(3'd1, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        check("lat_n1_no_start", 32'(add_start), 32'd0);
        tick();
        check("lat_n2_add_start", 32'(add_start), 32'd1);
        check("lat_n2_tag", 32'(op_tag), 32'd1);
        check("lat_n2_opa", operand_a, 32'h3F80_0000);
        check("lat_n2_opb", operand_b, 32'h4000_0000);
        tick();
        check("start_one_cycle", 32'(add_start), 32'd0);
        check("tag_held", 32'(op_tag), 32'd1);
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        check("tag_cleared", 32'(op_tag), 32'd0);

        // SUB sign flip and COS select.
        auto_ack = 1'b1;
        push_cmd(3'd2, $urandom, 32'h4000_0000, 1'b1);
        push_cmd(3'd5, $urandom, $urandom, 1'b1);
        wait_drain();

        // Fill while stalled in WAIT; ninth push is dropped.
        auto_ack = 1'b0;
        push_cmd(3'd3, $urandom, $urandom, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 9; i++)
            push_cmd(3'($urandom_range(1, 5)), $urandom, $urandom, i < 8);
        check("full_count", 32'(in_count), 32'd8);
        check("full_flag", 32'(in_full), 32'd1);
        check("overflow_flag", 32'(err_overflow), 32'(exp_overflow));
        auto_ack = 1'b1;
        wait_drain();

        // Illegal opcode then MUL.
        check("illegal_before", 32'(err_illegal), 32'd0);
        push_cmd(3'd7, $urandom, $urandom, 1'b1);
        push_cmd(3'd3, $urandom, $urandom, 1'b1);
        wait_drain();
        check("illegal_after", 32'(err_illegal), 32'(exp_illegal));

        // Collector hold blocks issue.
        out_fifo_hold = 1'b1;
        push_cmd(3'd1, $urandom, $urandom, 1'b1);
        push_cmd(3'd4, $urandom, $urandom, 1'b1);
        s0 = start_events;
        repeat (5) tick();
        check("hold_no_start", 32'(start_events), 32'(s0));
        check("hold_count", 32'(in_count), 32'd2);
        out_fifo_hold = 1'b0;
        tick();
        check("release_issue", 32'(add_start | mul_start | sine_start), 32'd1);
        wait_drain();

        // Random traffic including NOPs, illegal codes and collector holds.
        for (int i = 0; i < 300; i++) begin
            out_fifo_hold = ($urandom_range(0, 7) == 0);
            if (in_count < 4'd6 && $urandom_range(0, 2) == 0)
                push_cmd(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1);
            else
                tick();
        end
        out_fifo_hold = 1'b0;
        wait_drain();
        check("rand_illegal", 32'(err_illegal), 32'(exp_illegal));
        check("rand_overflow", 32'(err_overflow), 32'(exp_overflow));

`ifdef DISPATCH_TIMEOUT_EN
        begin
            int waited = 0;
            int pulses = 0;
            auto_ack = 1'b0;
            push_cmd(3'd1, $urandom, $urandom, 1'b1);
            tick();
            tick();
            while (err_timeout !== 1'b1 && waited < 400) begin
                tick();
                waited++;
            end
            check("timeout_cycles", 32'(waited), 32'd255);
            check("timeout_tag", 32'(op_tag), 32'd0);
            for (int i = 0; i < 20; i++) begin
                tick();
                if (err_timeout) pulses++;
            end
            check("timeout_single_pulse", 32'(pulses), 32'd0);
            auto_ack = 1'b1;
            push_cmd(3'd3, $urandom, $urandom, 1'b1);
            wait_drain();
        end
`endif

        // Reset during WAIT with queued commands.
        auto_ack = 1'b0;
        push_cmd(3'd1, $urandom, $urandom, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) push_cmd(3'd3, $urandom, $urandom, 1'b1);
        tick();
        ra = 32'(in_count);
        check("pre_reset_count", ra, 32'd3);
        sb.delete();
        exp_illegal  = 1'b0;
        exp_overflow = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tag", 32'(op_tag), 32'd0);
        check("midrst_count", 32'(in_count), 32'd0);
        check("midrst_errs", 32'({err_illegal, err_overflow}), 32'd0);
        s0 = start_events;
        man_pop = 1'b1;
        tick();
        man_pop = 1'b0;
        repeat (10) tick();
        check("midrst_no_start", 32'(start_events), 32'(s0));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
